// File: rtl/mcp23s17_pkg.sv
// mcp23s17_pkg: register map, opcode constants and frame states for the MCP23S17 responder
package mcp23s17_pkg;
  localparam logic [7:0] IODIRA   = 8'h00;
  localparam logic [7:0] IODIRB   = 8'h01;
  localparam logic [7:0] IPOLA    = 8'h02;
  localparam logic [7:0] IPOLB    = 8'h03;
  localparam logic [7:0] GPINTENA = 8'h04;
  localparam logic [7:0] GPINTENB = 8'h05;
  localparam logic [7:0] INTFA    = 8'h0E;
  localparam logic [7:0] INTFB    = 8'h0F;
  localparam logic [7:0] INTCAPA  = 8'h10;
  localparam logic [7:0] INTCAPB  = 8'h11;
  localparam logic [7:0] GPIOA    = 8'h12;
  localparam logic [7:0] GPIOB    = 8'h13;
  localparam logic [7:0] OLATA    = 8'h14;
  localparam logic [7:0] OLATB    = 8'h15;
  localparam logic [3:0] OPCODE_BASE = 4'b0100;
  localparam logic [7:0] ADDR_LAST   = 8'h15;
  typedef enum logic [2:0] {ST_IDLE, ST_OPCODE, ST_ADDR, ST_DATA, ST_IGNORE} frame_state_e;
endpackage

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: mode-0 SPI front end with synchronisers, edge detect, byte assembly and MISO shifter
module spi_slave_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  input  logic [15:0] pins,
  input  logic        load,
  input  logic [7:0]  load_data,
  output logic [15:0] pins_s,
  output logic        cs_n_s,
  output logic        cs_fall,
  output logic        sck_fall,
  output logic        bit_zero,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        miso
);
  // [1] is the synchronised level, [2] its previous value for edge detection
  logic [2:0] sck_q, sck_d, cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;
  logic [15:0] pin1_q, pin1_d, pin2_q, pin2_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_in_q, sr_in_d, sr_out_q, sr_out_d;
  logic sck_rise;
  always_comb begin
    sck_d = {sck_q[1:0], sck};
    cs_d = {cs_q[1:0], cs_n};
    mosi_d = {mosi_q[0], mosi};
    pin1_d = pins;
    pin2_d = pin1_q;
    pins_s = pin2_q;
    cs_n_s = cs_q[1];
    cs_fall = ~cs_q[1] & cs_q[2];
    sck_rise = sck_q[1] & ~sck_q[2] & ~cs_q[1];
    sck_fall = ~sck_q[1] & sck_q[2] & ~cs_q[1];
    bit_zero = cnt_q == 3'd0;
    byte_valid = sck_rise & (cnt_q == 3'd7);
    byte_data = {sr_in_q[6:0], mosi_q[1]};
    sr_in_d = sck_rise ? byte_data : sr_in_q;
    cnt_d = (cs_q[1] | cs_fall) ? 3'd0 : cnt_q + {2'd0, sck_rise};
    sr_out_d = sck_fall ? (load ? load_data : {sr_out_q[6:0], 1'b0}) : sr_out_q;
    miso = sr_out_q[7];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 3'b000;
      cs_q <= 3'b111;
      mosi_q <= 2'b00;
      pin1_q <= 16'h0000;
      pin2_q <= 16'h0000;
      cnt_q <= 3'd0;
      sr_in_q <= 8'h00;
      sr_out_q <= 8'h00;
    end else begin
      sck_q <= sck_d;
      cs_q <= cs_d;
      mosi_q <= mosi_d;
      pin1_q <= pin1_d;
      pin2_q <= pin2_d;
      cnt_q <= cnt_d;
      sr_in_q <= sr_in_d;
      sr_out_q <= sr_out_d;
    end
  end
endmodule

// File: rtl/mcp23s17_responder.sv
// mcp23s17_responder: MCP23S17 (BANK=0 subset) SPI port-expander emulation with interrupt-on-change
module mcp23s17_responder
  import mcp23s17_pkg::*;
#(
  parameter logic [2:0] HW_ADDR    = 3'b000,
  parameter bit         CHECK_ADDR = 1'b0
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic       SPI_SCK,
  input  logic       SPI_CS_N,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_OE,
  input  logic [7:0] GPA_IN,
  input  logic [7:0] GPB_IN,
  output logic [7:0] GPA_OUT,
  output logic [7:0] GPB_OUT,
  output logic [7:0] GPA_OE,
  output logic [7:0] GPB_OE,
  output logic       INTA_N
);
  frame_state_e state_q, state_d;
  logic rw_q, rw_d, oe_q, oe_d, inta_q, inta_d;
  logic [7:0] addr_q, addr_d, rd_data, byte_data;
  logic [1:0][7:0] iodir_q, iodir_d, ipol_q, ipol_d, gpinten_q, gpinten_d, olat_q, olat_d;
  logic [1:0][7:0] intf_q, intf_d, intcap_q, intcap_d, prev_q, prev_d, pin_s, gpio, chg;
  logic [1:0] clr;
  logic load, cs_n_s, cs_fall, sck_fall, bit_zero, byte_valid, bad_op, port;
  spi_slave_shifter u_shift (
    .clk(CLK_50), .rst_n(RESET_N), .sck(SPI_SCK), .cs_n(SPI_CS_N), .mosi(SPI_MOSI),
    .pins({GPB_IN, GPA_IN}), .load(load), .load_data(rd_data), .pins_s(pin_s),
    .cs_n_s(cs_n_s), .cs_fall(cs_fall), .sck_fall(sck_fall), .bit_zero(bit_zero),
    .byte_valid(byte_valid), .byte_data(byte_data), .miso(SPI_MISO)
  );
  assign port = addr_q[0];
  assign gpio = pin_s ^ (ipol_q & iodir_q);
  always_comb begin
    case (addr_q[7:1])
      IODIRA[7:1]:   rd_data = iodir_q[port];
      IPOLA[7:1]:    rd_data = ipol_q[port];
      GPINTENA[7:1]: rd_data = gpinten_q[port];
      INTFA[7:1]:    rd_data = intf_q[port];
      INTCAPA[7:1]:  rd_data = intcap_q[port];
      GPIOA[7:1]:    rd_data = gpio[port];
      OLATA[7:1]:    rd_data = olat_q[port];
      default:       rd_data = 8'h00;
    endcase
  end
  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    addr_d = addr_q;
    oe_d = oe_q;
    iodir_d = iodir_q;
    ipol_d = ipol_q;
    gpinten_d = gpinten_q;
    olat_d = olat_q;
    intf_d = intf_q;
    intcap_d = intcap_q;
    prev_d = pin_s;
    inta_d = ~|intf_q;
    load = 1'b0;
    clr = 2'b00;
    chg = gpinten_q & iodir_q & (pin_s ^ prev_q);
    bad_op = (byte_data[7:4] != OPCODE_BASE) || (CHECK_ADDR && (byte_data[3:1] != HW_ADDR));
    if (cs_n_s) begin
      state_d = ST_IDLE;
      oe_d = 1'b0;
    end else if (cs_fall) begin
      state_d = ST_OPCODE;
    end else begin
      case (state_q)
        ST_OPCODE: if (byte_valid) begin
          state_d = bad_op ? ST_IGNORE : ST_ADDR;
          rw_d = byte_data[0];
        end
        ST_ADDR: if (byte_valid) begin
          state_d = ST_DATA;
          addr_d = byte_data;
        end
        ST_DATA: begin
          load = rw_q & sck_fall & bit_zero;
          oe_d = oe_q | load;
          if (byte_valid) begin
            addr_d = (addr_q == ADDR_LAST) ? 8'h00 : addr_q + 8'd1;
            if (rw_q) clr[port] = (addr_q[7:1] == GPIOA[7:1]) || (addr_q[7:1] == INTCAPA[7:1]);
            else begin
              case (addr_q[7:1])
                IODIRA[7:1]:             iodir_d[port] = byte_data;
                IPOLA[7:1]:              ipol_d[port] = byte_data;
                GPINTENA[7:1]:           gpinten_d[port] = byte_data;
                GPIOA[7:1], OLATA[7:1]:  olat_d[port] = byte_data;
                default: ;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
    // a change arriving in the same cycle as a clearing read re-arms the flag
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) intf_d[i] = 8'h00;
      if (|chg[i] && (~|intf_q[i] || clr[i])) begin
        intf_d[i] = chg[i];
        intcap_d[i] = gpio[i];
      end
    end
  end
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      rw_q <= 1'b0;
      addr_q <= 8'h00;
      oe_q <= 1'b0;
      inta_q <= 1'b1;
      iodir_q <= {2{8'hFF}};
      ipol_q <= '0;
      gpinten_q <= '0;
      olat_q <= '0;
      intf_q <= '0;
      intcap_q <= '0;
      prev_q <= '0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      oe_q <= oe_d;
      inta_q <= inta_d;
      iodir_q <= iodir_d;
      ipol_q <= ipol_d;
      gpinten_q <= gpinten_d;
      olat_q <= olat_d;
      intf_q <= intf_d;
      intcap_q <= intcap_d;
      prev_q <= prev_d;
    end
  end
  assign SPI_MISO_OE = oe_q;
  assign GPA_OUT = olat_q[0];
  assign GPB_OUT = olat_q[1];
  assign GPA_OE = ~iodir_q[0];
  assign GPB_OE = ~iodir_q[1];
  assign INTA_N = inta_q;
endmodule
